// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master / one-slave Wishbone arbiter for the CPU memory bus.
//   Master 0 = instruction fetcher, master 1 = load/store unit.
//   Round-robin grant per cycle-group; the grant is held while the owner keeps cyc high.
//   A watchdog aborts a slave access that gets no ack/err within TIMEOUT cycles,
//   answering the owner with a synthetic err so the CPU cannot deadlock.
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_mN_cyc/stb/we/addr/dat master N request (N = 0, 1)
//   o_mN_dat/ack/err         master N return path (ack/err only reach the owner)
//   o_s_cyc/stb/we/addr/dat  slave request (muxed from the owner)
//   i_s_dat/ack/err          slave response
//   o_gnt                    one-hot current owner (bit n = master n)
//   o_timeout                one-cycle pulse when the watchdog aborts an access
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_cyc,
  input  logic [3:0]  i_m0_stb,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_dat,
  output logic [31:0] o_m0_dat,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic        i_m1_cyc,
  input  logic [3:0]  i_m1_stb,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_dat,
  output logic [31:0] o_m1_dat,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic        o_s_cyc,
  output logic [3:0]  o_s_stb,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_dat,
  input  logic [31:0] i_s_dat,
  input  logic        i_s_ack,
  input  logic        i_s_err,
  output logic [1:0]  o_gnt,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

  state_t        state, state_n;
  logic          last, last_n;     // master served most recently
  logic          owner, owner_n;   // current owner; meaningful outside IDLE
  logic [TW-1:0] wdog, wdog_n;
  logic          timeout_n;

  logic          in_own, active, resp, wd_hit, release_bus;
  logic          sel_cyc, other_cyc, sel_we;
  logic [3:0]    sel_stb;
  logic [31:0]   sel_addr, sel_dat;
  logic          fwd_ack, fwd_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      wdog      <= '0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      owner     <= owner_n;
      wdog      <= wdog_n;
      o_timeout <= timeout_n;
    end
  end

  always_comb begin
    sel_cyc   = owner ? i_m1_cyc  : i_m0_cyc;
    other_cyc = owner ? i_m0_cyc  : i_m1_cyc;
    sel_stb   = owner ? i_m1_stb  : i_m0_stb;
    sel_we    = owner ? i_m1_we   : i_m0_we;
    sel_addr  = owner ? i_m1_addr : i_m0_addr;
    sel_dat   = owner ? i_m1_dat  : i_m0_dat;

    in_own  = (state == OWN0) || (state == OWN1);
    active  = in_own && sel_cyc;
    resp    = i_s_ack || i_s_err;
    wd_hit  = active && !resp && (wdog == TW'(TIMEOUT - 1));

    // Slave side: nothing driven outside an owned state, stb gated by cyc.
    o_s_cyc  = active;
    o_s_stb  = active ? sel_stb : '0;
    o_s_we   = in_own && sel_we;
    o_s_addr = in_own ? sel_addr : '0;
    o_s_dat  = in_own ? sel_dat  : '0;

    // Responses reach only the owner; ABORT and IDLE swallow them.
    fwd_ack  = in_own && i_s_ack;
    fwd_err  = in_own && (i_s_err || wd_hit);
    o_m0_ack = fwd_ack && !owner;
    o_m0_err = fwd_err && !owner;
    o_m1_ack = fwd_ack && owner;
    o_m1_err = fwd_err && owner;
    o_m0_dat = i_s_dat;
    o_m1_dat = i_s_dat;

    o_gnt = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

    state_n     = state;
    last_n      = last;
    owner_n     = owner;
    wdog_n      = wdog;
    timeout_n   = 1'b0;
    release_bus = 1'b0;

    case (state)
      IDLE: begin
        if (i_m0_cyc || i_m1_cyc) begin
          owner_n = (i_m0_cyc && i_m1_cyc) ? ~last : i_m1_cyc;
          state_n = owner_n ? OWN1 : OWN0;
          wdog_n  = '0;
        end
      end
      OWN0, OWN1: begin
        if (!sel_cyc) begin
          release_bus = 1'b1;
        end else if (wd_hit) begin
          state_n   = ABORT;
          timeout_n = 1'b1;
        end else begin
          wdog_n = resp ? '0 : wdog + TW'(1);
        end
      end
      ABORT: begin
        if (!sel_cyc) release_bus = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Hand the bus straight to a waiting master so no idle cycle is inserted.
    if (release_bus) begin
      last_n = owner;
      if (other_cyc) begin
        owner_n = ~owner;
        state_n = owner ? OWN0 : OWN1;
        wdog_n  = '0;
      end else begin
        state_n = IDLE;
      end
    end
  end

endmodule
